feature_map_stream_fifo: RTL and testbench
==========================================

// Module: feature_map_stream_fifo
// PURPOSE
//  Elastic, handshaked stage for multi-channel feature vectors between conv/pool layers.
//  Buffers up to FIFO_DEPTH vectors with valid/ready on both sides.
//  Tags each vector with its raster position in an FMAP_W x FMAP_H map.
//  Downstream line buffers use the tags to find row and frame ends.
// PARAMETERS
//  FEATURE_WIDTH  16  signed bits per channel
//  FEATURE_DEPTH  6   channels per vector
//  FIFO_DEPTH     4   storage entries; power of 2, >= 2
//  FMAP_W         28  feature-map columns per row, >= 1
//  FMAP_H         28  feature-map rows per frame, >= 1
// PORTS
//  clk           in   1                        rising-edge clock
//  rst           in   1                        async, active-high reset
//  in_valid      in   1                        upstream vector valid
//  in_ready      out  1                        stage can accept a vector
//  features_in   in   FEATURE_WIDTH x FEATURE_DEPTH  signed input vector
//  out_valid     out  1                        head entry valid
//  out_ready     in   1                        downstream accepts head
//  features_out  out  FEATURE_WIDTH x FEATURE_DEPTH  signed head vector
//  out_last_col  out  1                        head vector is in column FMAP_W-1
//  out_last_row  out  1                        head vector is in row FMAP_H-1
//  level         out  $clog2(FIFO_DEPTH+1)     entries currently held
// BEHAVIOUR
//  - Push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (level != FIFO_DEPTH). It is combinational from registered state only.
//  - out_valid = (level != 0).
//  - No combinational path from in_valid to out_valid, or from out_ready to in_ready.
//  - Latency: a vector pushed at edge N is presented with out_valid=1 after edge N.
//    No fall-through while empty.
//  - features_out, out_last_col and out_last_row come from the head entry (read-pointer mux).
//  - All outputs hold stable while out_valid=1 and out_ready=0.
//  - Storage entry = {last_row, last_col, FEATURE_DEPTH x FEATURE_WIDTH} bits.
//    Channel order is preserved: index k in gives index k out.
//  - Position counters col (0..FMAP_W-1) and row (0..FMAP_H-1) advance only on push.
//    - Tags written with each entry: last_col = (col==FMAP_W-1), last_row = (row==FMAP_H-1).
//    - On push: if col==FMAP_W-1 then col<=0, and row<=(row==FMAP_H-1) ? 0 : row+1;
//      otherwise col<=col+1.
//    - The frame wraps back to (0,0) with no idle cycle.
//  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//  - level updates on each edge:
//    +1 on push only; -1 on pop only; unchanged on push & pop, or on neither.
//  - Full (level==FIFO_DEPTH):
//    - in_ready=0, so no push even if a pop occurs in the same cycle.
//    - in_ready returns to 1 in the cycle after the pop.
//  - Empty (level==0): out_valid=0; out_ready is ignored; level never underflows.
//  - Simultaneous push & pop with 0<level<FIFO_DEPTH:
//    both pointers advance; level is unchanged.
//  - Data values pass through unmodified. No arithmetic and no saturation.
//  - Reset (async assert, sampled release) sets:
//    - rd_ptr=wr_ptr=0, level=0, col=0, row=0.
//    - All storage to 0, so features_out=0, out_last_col=0, out_last_row=0.
//    - out_valid=0 and in_ready=1 immediately on assert.
//  - Reset mid-frame discards buffered data. The next push after release is tagged
//    as position (0,0).
// TESTING (FIFO_DEPTH=4, FMAP_W=3, FMAP_H=2, FEATURE_DEPTH=6)
//  - Reset, then push ch[k]=k+1 with out_ready=1:
//    out_valid=1 one cycle later, features_out={1..6}, level=1 then 0.
//  - Push 6 vectors (values -1..-6 on ch0) with out_ready=1 throughout:
//    - last_col=1 on outputs 3 and 6; last_row=1 on outputs 4..6.
//    - Push 7 is tagged (0,0) again.
//  - Hold out_ready=0 and push 5 vectors:
//    - in_ready=0 after the 4th push; level=4; the 5th is held upstream.
//    - Raise out_ready for 1 cycle: entry 1 pops, in_ready=1 on the next cycle,
//      then the 5th is accepted.
//  - level=2, in_valid=out_ready=1 for 10 cycles:
//    level stays 2; output order equals input order; no drops or duplicates.
//  - Assert rst mid-stream with level=3, col=1:
//    - Immediately out_valid=0, in_ready=1, level=0, features_out=0.
//    - First push after release has last_col=0, last_row=0.
//  - Random valid/ready (50%) over 1000 vectors against a scoreboard:
//    data and tags match the reference queue; stall stability assertion holds.

Source files
------------

// File: rtl/feature_map_stream_fifo.sv
// feature_map_stream_fifo
//   Elastic valid/ready buffer for multi-channel feature vectors. Each vector is
//   tagged on entry with whether it sits in the last column and/or last row of an
//   FMAP_W x FMAP_H raster. Downstream line buffers use these tags to find row
//   and frame boundaries. in_ready and out_valid depend only on registered state,
//   so neither side's handshake input reaches the other side's handshake output.
module feature_map_stream_fifo #(
   parameter int FEATURE_WIDTH = 16,
   parameter int FEATURE_DEPTH = 6,
   parameter int FIFO_DEPTH    = 4,
   parameter int FMAP_W        = 28,
   parameter int FMAP_H        = 28
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                in_valid,
   output logic                                                in_ready,
   input  logic signed [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0]  features_in,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic signed [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0]  features_out,
   output logic                                                out_last_col,
   output logic                                                out_last_row,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]                     level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int COL_W = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
   localparam int ROW_W = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;

   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

   // One storage entry: position tags above the channel vector.
   typedef struct packed {
      logic                                        last_row;
      logic                                        last_col;
      logic [FEATURE_DEPTH-1:0][FEATURE_WIDTH-1:0] data;
   } entry_t;

   entry_t             mem [FIFO_DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic               push;
   logic               pop;
   logic               at_last_col;
   logic               at_last_row;

   // Handshake decode is taken from the registered level only.
   assign in_ready    = (level != LVL_FULL);
   assign out_valid   = (level != '0);
   assign push        = in_valid & in_ready;
   assign pop         = out_valid & out_ready;
   assign at_last_col = (col == COL_LAST);
   assign at_last_row = (row == ROW_LAST);

   // The head entry drives all outputs, so they hold while the consumer stalls.
   assign head         = mem[rd_ptr];
   assign features_out = head.data;
   assign out_last_col = head.last_col;
   assign out_last_row = head.last_row;

   // Storage write: the incoming vector plus its raster tags goes to the write pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is reset on purpose so an empty stage presents all-zero
         // data and tags; this costs a reset net per storage flop.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= '{last_row: at_last_row, last_col: at_last_col, data: features_in};
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Raster position of the next accepted vector; advances only on push and
   // wraps from the last pixel of a frame straight back to (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (push) begin
         if (at_last_col) begin
            col <= '0;
            row <= at_last_row ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_feature_map_stream_fifo.sv
// Self-checking bench for feature_map_stream_fifo. A queue-based reference model
// derives occupancy, handshakes, head data and raster tags from the push count.
module tb_feature_map_stream_fifo;

   localparam int FW = 16;
   localparam int FD = 6;
   localparam int DEPTH = 4;
   localparam int W = 3;
   localparam int H = 2;

   typedef logic signed [FD-1:0][FW-1:0] vec_t;
   typedef struct {
      vec_t data;
      bit   lc;
      bit   lr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   vec_t       features_in = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   vec_t       features_out;
   logic       out_last_col;
   logic       out_last_row;
   logic [2:0] level;

   exp_t q[$];
   int   n_push = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   feature_map_stream_fifo #(
      .FEATURE_WIDTH(FW), .FEATURE_DEPTH(FD), .FIFO_DEPTH(DEPTH),
      .FMAP_W(W), .FMAP_H(H)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .features_in(features_in),
      .out_valid(out_valid), .out_ready(out_ready), .features_out(features_out),
      .out_last_col(out_last_col), .out_last_row(out_last_row), .level(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compare the DUT's visible state against the model (called away from the edge).
   task automatic check_outputs(input string ph);
      check({ph, "_level"}, level, q.size());
      check({ph, "_in_ready"}, in_ready, q.size() != DEPTH);
      check({ph, "_out_valid"}, out_valid, q.size() != 0);
      if (q.size() != 0) begin
         check({ph, "_data"}, features_out, q[0].data);
         check({ph, "_last_col"}, out_last_col, q[0].lc);
         check({ph, "_last_row"}, out_last_row, q[0].lr);
      end
   endtask

   // Raster tags follow from the ordinal number of the push within a frame.
   function automatic exp_t make_entry(input vec_t d, input int idx);
      exp_t e;
      int   p;
      p = idx % (W * H);
      e.data = d;
      e.lc = ((p % W) == W - 1);
      e.lr = ((p / W) == H - 1);
      return e;
   endfunction

   // One clock: check, drive, clock, update the model.
   task automatic step(input string ph, input logic v, input logic r, input vec_t d);
      bit do_push;
      bit do_pop;
      check_outputs(ph);
      in_valid = v;
      out_ready = r;
      features_in = d;
      do_push = v && (q.size() != DEPTH);
      do_pop = r && (q.size() != 0);
      @(posedge clk);
      #1;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         q.push_back(make_entry(d, n_push));
         n_push++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      n_push = 0;
      rst = 1'b0;
   endtask

   task automatic drain(input string ph);
      for (int i = 0; i < 20 && q.size() != 0; i++) step(ph, 1'b0, 1'b1, '0);
      check({ph, "_drained"}, q.size(), 0);
      check_outputs(ph);
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      for (int k = 0; k < FD; k++) v[k] = FW'($urandom);
      return v;
   endfunction

   initial begin
      vec_t v;
      int   pushed;

      // 1: reset state, then a single vector with ch[k]=k+1
      do_reset();
      check("rst_data", features_out, 0);
      check("rst_last_col", out_last_col, 0);
      check("rst_last_row", out_last_row, 0);
      for (int k = 0; k < FD; k++) v[k] = FW'(k + 1);
      step("single", 1'b1, 1'b1, v);
      step("single", 1'b0, 1'b1, '0);
      check_outputs("single");

      // 2: seven vectors streaming through; the seventh wraps to (0,0)
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         v = rand_vec();
         v[0] = -FW'(i);
         step("stream", 1'b1, 1'b1, v);
      end
      drain("stream");

      // 3: fill with the consumer stalled, fifth vector held upstream
      do_reset();
      for (int i = 1; i <= 5; i++) step("fill", 1'b1, 1'b0, rand_vec());
      check("full_level", level, 4);
      check("full_in_ready", in_ready, 0);
      v = rand_vec();
      step("fill", 1'b1, 1'b1, v);
      check("after_pop_in_ready", in_ready, 1);
      step("fill", 1'b1, 1'b0, v);
      check("refill_level", level, 4);
      drain("fill");

      // 4: steady state at level 2 with both sides active
      do_reset();
      step("steady", 1'b1, 1'b0, rand_vec());
      step("steady", 1'b1, 1'b0, rand_vec());
      for (int i = 0; i < 10; i++) step("steady", 1'b1, 1'b1, rand_vec());
      check("steady_level", level, 2);
      drain("steady");

      // 5: asynchronous reset with level=3, col=1
      do_reset();
      for (int i = 0; i < 4; i++) step("midrst", 1'b1, 1'b0, rand_vec());
      step("midrst", 1'b0, 1'b1, '0);
      check("pre_rst_level", level, 3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_level", level, 0);
      check("arst_data", features_out, 0);
      check("arst_last_col", out_last_col, 0);
      check("arst_last_row", out_last_row, 0);
      do_reset();
      step("postrst", 1'b1, 1'b0, rand_vec());
      check("postrst_last_col", out_last_col, 0);
      check("postrst_last_row", out_last_row, 0);
      drain("postrst");

      // 6: random valid/ready traffic against the model
      do_reset();
      pushed = 0;
      for (int cyc = 0; cyc < 20000 && pushed < 1000; cyc++) begin
         logic vv;
         logic rr;
         vv = 1'($urandom);
         rr = 1'($urandom);
         if (vv && q.size() != DEPTH) pushed++;
         step("rand", vv, rr, rand_vec());
      end
      check("rand_count", pushed, 1000);
      drain("rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound in case something stalls the stimulus.
   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
